// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath width, reset PC, NOP encoding
// and the fetch FSM state type.
package mips_pkg;

    localparam int unsigned INST_W = 32;

    localparam logic [INST_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INST_W-1:0] NOP              = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel and
// the valid/ready instruction hand-off to decode.
interface fetch_stage_if;
    import mips_pkg::*;

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [INST_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;

    logic              if_valid;
    logic              if_ready;
    logic [INST_W-1:0] if_inst;
    logic [INST_W-1:0] if_pc;
    logic [INST_W-1:0] if_pc_plus4;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output if_valid, if_inst, if_pc, if_pc_plus4,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  if_valid, if_inst, if_pc, if_pc_plus4,
        output if_ready
    );

endinterface

// File: rtl/fetch_perf_cnt.sv
// Fetch performance counters: instructions handed to decode and decode
// stall cycles, both free-running and wrapping.
module fetch_perf_cnt
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic              if_ready,
    output logic [INST_W-1:0] fetch_cnt,
    output logic [INST_W-1:0] stall_cnt
);

    logic [INST_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [INST_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (if_valid && if_ready) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (if_valid && !if_ready) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC owner, single-outstanding imem requester
// and IF/ID output register. Define IFETCH_PERF_EN to build the perf counters.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [INST_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    fetch_stage_if.master     bus,
    input  logic              redirect_valid,
    input  logic [INST_W-1:0] redirect_pc,
    output logic [INST_W-1:0] perf_fetch_cnt,
    output logic [INST_W-1:0] perf_stall_cnt
);

    fetch_state_e      state_q, state_d;
    logic [INST_W-1:0] pc_q, pc_d;
    logic              if_valid_q, if_valid_d;
    logic [INST_W-1:0] if_inst_q, if_inst_d;
    logic [INST_W-1:0] if_pc_q, if_pc_d;
    logic              req_valid;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_inst_d  = if_inst_q;
        if_pc_d    = if_pc_q;
        req_valid  = (state_q == S_REQ) && (!if_valid_q || bus.if_ready) && !redirect_valid;

        if (if_valid_q && bus.if_ready) begin
            if_valid_d = 1'b0;
        end

        // A redirect overrides any load; an in-flight response becomes stale.
        if (redirect_valid) begin
            pc_d       = redirect_pc & ~32'd3;
            if_valid_d = 1'b0;
            case (state_q)
                S_REQ:          state_d = S_REQ;
                S_WAIT, S_DROP: state_d = bus.imem_rsp_valid ? S_REQ : S_DROP;
                default:        state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (req_valid && bus.imem_req_ready) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        if_inst_d  = bus.imem_rsp_data;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        pc_d       = pc_q + 32'd4;
                        state_d    = S_REQ;
                    end
                end
                S_DROP: begin
                    if (bus.imem_rsp_valid) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_inst_q  <= NOP;
            if_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_inst_q  <= if_inst_d;
            if_pc_q    <= if_pc_d;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.if_valid       = if_valid_q;
    assign bus.if_inst        = if_inst_q;
    assign bus.if_pc          = if_pc_q;
    assign bus.if_pc_plus4    = if_pc_q + 32'd4;

`ifdef IFETCH_PERF_EN
    fetch_perf_cnt u_perf (
        .clk       (clk),
        .rst       (rst),
        .if_valid  (if_valid_q),
        .if_ready  (bus.if_ready),
        .fetch_cnt (perf_fetch_cnt),
        .stall_cnt (perf_stall_cnt)
    );
`else
    assign perf_fetch_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule
